// File: rtl/ethernet_system_lcd_timed.sv
// ethernet_system_lcd_timed
// Avalon-MM slave that runs one HD44780-style bus cycle per host access,
// with programmable setup / E-pulse / hold lengths. The host is held off
// with waitrequest until the LCD cycle has finished.
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   address[1:0] bit0 = RW (1 = LCD read), bit1 = RS (1 = data register)
//   read, write  Avalon strobes; either one starts a transaction
//   writedata    byte to send to the LCD
//   readdata     byte captured from the LCD, valid from DONE onward
//   waitrequest  Avalon stall, low only during the DONE cycle
//   LCD_E/RS/RW  registered LCD control lines
//   LCD_data     LCD bus, driven only during write cycles
module ethernet_system_lcd_timed #(
    parameter int BUS_WIDTH    = 8,
    parameter int SETUP_CYCLES = 3,
    parameter int PULSE_CYCLES = 12,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [7:0]           writedata,
    output logic [7:0]           readdata,
    output logic                 waitrequest,
    output logic                 LCD_E,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    inout  wire  [BUS_WIDTH-1:0] LCD_data
);

    localparam int MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam bit               FOUR_BIT   = (BUS_WIDTH == 4);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_nibble;
    logic                 w_nibble_nxt;
    logic                 r_lcd_e;
    logic                 r_lcd_rs;
    logic                 r_lcd_rw;
    logic                 r_drive_en;
    logic [BUS_WIDTH-1:0] r_dout;
    logic [7:0]           r_readdata;

    logic                 w_accept;
    logic                 w_second_beat;
    logic                 w_rd_sample;
    logic [BUS_WIDTH-1:0] w_beat0;
    logic [BUS_WIDTH-1:0] w_beat1;
    logic [7:0]           w_rd_next;

    assign w_accept      = (r_state == ST_IDLE) & (read | write);
    assign w_second_beat = (r_state == ST_HOLD) & (w_state_nxt == ST_SETUP);
    // Last PULSE cycle of a read: the LCD output is still valid before E falls.
    assign w_rd_sample   = (r_state == ST_PULSE) & (w_state_nxt == ST_HOLD) & r_lcd_rw;

    generate
        if (FOUR_BIT) begin : g_nibble
            logic [3:0] r_wdata_lo;

            // Keep the low nibble for the second beat; writedata may change after accept.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wdata_lo <= 4'h0;
                end else if (w_accept) begin
                    r_wdata_lo <= writedata[3:0];
                end else begin
                    r_wdata_lo <= r_wdata_lo;
                end
            end

            assign w_beat0   = writedata[7:4];
            assign w_beat1   = r_wdata_lo;
            assign w_rd_next = r_nibble ? {r_readdata[7:4], LCD_data}
                                        : {LCD_data, r_readdata[3:0]};
        end else begin : g_byte
            assign w_beat0   = writedata;
            assign w_beat1   = r_dout;
            assign w_rd_next = LCD_data;
        end
    endgenerate

    // Next-state, cycle counter and nibble flag decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_nibble_nxt = r_nibble;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (read | write) begin
                    w_state_nxt  = ST_SETUP;
                    w_nibble_nxt = 1'b0;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt = '0;
                    if (FOUR_BIT && !r_nibble) begin
                        w_state_nxt  = ST_SETUP;
                        w_nibble_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_cnt_nxt    = '0;
                w_nibble_nxt = 1'b0;
            end
        endcase
    end

    // State register, counter and E strobe (E decoded from the next state).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_nibble <= 1'b0;
            r_lcd_e  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_nibble <= w_nibble_nxt;
            r_lcd_e  <= (w_state_nxt == ST_PULSE);
        end
    end

    // RS/RW, bus driver enable and output data beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_drive_en <= 1'b0;
            r_dout     <= '0;
        end else if (w_accept) begin
            r_lcd_rs   <= address[1];
            r_lcd_rw   <= address[0];
            r_drive_en <= ~address[0];
            r_dout     <= w_beat0;
        end else if (w_second_beat) begin
            r_dout     <= w_beat1;
        end else if (w_state_nxt == ST_DONE) begin
            r_drive_en <= 1'b0;
        end else begin
            r_drive_en <= r_drive_en;
        end
    end

    // Read data capture at the end of each read pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 8'h00;
        end else if (w_rd_sample) begin
            r_readdata <= w_rd_next;
        end else begin
            r_readdata <= r_readdata;
        end
    end

    assign LCD_data    = r_drive_en ? r_dout : {BUS_WIDTH{1'bz}};
    assign LCD_E       = r_lcd_e;
    assign LCD_RS      = r_lcd_rs;
    assign LCD_RW      = r_lcd_rw;
    assign readdata    = r_readdata;
    assign waitrequest = (read | write) & (r_state != ST_DONE);

endmodule
